// File: rtl/mem_responder_pkg.sv
// Shared memory-port types: access width, responder FSM states, latched request and lane-mask helper.
package mem_port_types;

    localparam int          NUM_LANES = 4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        MEM_WIDTH_BYTE = 2'd0,
        MEM_WIDTH_HALF = 2'd1,
        MEM_WIDTH_WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WAIT,
        RESP_RESP
    } resp_state_t;

    typedef struct packed {
        logic       we;
        mem_width_t width;
        logic       mis;
        logic [31:0] data;
    } mem_req_t;

    // Byte enables for an access of width w starting at byte offset a within the word.
    function automatic logic [NUM_LANES-1:0] lane_mask(input mem_width_t w, input logic [1:0] a);
        case (w)
            MEM_WIDTH_BYTE: lane_mask = 4'b0001 << a;
            MEM_WIDTH_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:        lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// mem_byte_ram: word-organised RAM with one byte lane per generate slice, per-lane write enable,
// synchronous write and asynchronous word read.
module mem_byte_ram
    import mem_port_types::*;
#(
    parameter int AW = 10
) (
    input  logic                      clk,
    input  logic [NUM_LANES-1:0]      we,
    input  logic [AW-1:0]             addr,
    input  logic [NUM_LANES-1:0][7:0] wdata,
    output logic [NUM_LANES-1:0][7:0] rdata
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [7:0] mem [2**AW];

        always_ff @(posedge clk) begin
            if (we[i]) mem[addr] <= wdata[i];
        end

        assign rdata[i] = mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-port target: latches a request, waits WAIT_STATES cycles, then completes it against mem_byte_ram.
// MEM_MISALIGN_ERR_EN adds the err port and rejects misaligned HALF/WORD accesses instead of aligning them.
module mem_responder
    import mem_port_types::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  width,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready
`ifdef MEM_MISALIGN_ERR_EN
    ,
    output logic        err
`endif
);

    resp_state_t          state;
    logic [3:0]           cnt;
    mem_req_t             req;
    logic [ADDR_BITS-1:0] req_addr;

    mem_width_t           in_w;
    logic                 in_mis;
    logic [31:0]          in_addr;
    logic                 unused_addr;

    assign in_w        = (width == 2'd3) ? MEM_WIDTH_WORD : mem_width_t'(width);
    assign unused_addr = ^addr[31:ADDR_BITS];

`ifdef MEM_MISALIGN_ERR_EN
    assign in_mis  = ((in_w == MEM_WIDTH_HALF) && addr[0]) ||
                     ((in_w == MEM_WIDTH_WORD) && (addr[1:0] != 2'b00));
    assign in_addr = addr;
`else
    assign in_mis  = 1'b0;
    always_comb begin
        in_addr = addr;
        case (in_w)
            MEM_WIDTH_HALF: in_addr = {addr[31:1], 1'b0};
            MEM_WIDTH_WORD: in_addr = addr & WORD_MASK;
            default:        in_addr = addr;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESP_IDLE;
            cnt      <= 4'd0;
            req      <= '0;
            req_addr <= '0;
        end else begin
            case (state)
                RESP_IDLE: begin
                    if (valid) begin
                        req.we    <= we;
                        req.width <= in_w;
                        req.mis   <= in_mis;
                        req.data  <= data_wr;
                        req_addr  <= in_addr[ADDR_BITS-1:0];
                        cnt       <= 4'(WAIT_STATES);
                        state     <= (WAIT_STATES == 0) ? RESP_RESP : RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!valid)           state <= RESP_IDLE;
                    else if (cnt == 4'd1) state <= RESP_RESP;
                end
                RESP_RESP: state <= RESP_IDLE;
                default:   state <= RESP_IDLE;
            endcase
        end
    end

    // Completion is gated by rst so a reset landing on the RESP cycle suppresses both ready and the store.
    logic in_resp;
    assign in_resp = (state == RESP_RESP) && !rst;

    logic [NUM_LANES-1:0]      ram_we;
    logic [NUM_LANES-1:0][7:0] ram_wdata;
    logic [NUM_LANES-1:0][7:0] ram_rdata;
    logic [31:0]               shifted;
    logic [31:0]               rd_ext;

    assign ram_we = (in_resp && req.we && !req.mis) ? lane_mask(req.width, req_addr[1:0]) : '0;

    always_comb begin
        ram_wdata = req.data;
        case (req.width)
            MEM_WIDTH_BYTE: ram_wdata = {4{req.data[7:0]}};
            MEM_WIDTH_HALF: ram_wdata = {2{req.data[15:0]}};
            default:        ram_wdata = req.data;
        endcase
    end

    mem_byte_ram #(.AW(ADDR_BITS - 2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_addr[ADDR_BITS-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign shifted = ram_rdata >> {req_addr[1:0], 3'b000};

    always_comb begin
        rd_ext = shifted;
        case (req.width)
            MEM_WIDTH_BYTE: rd_ext = {24'd0, shifted[7:0]};
            MEM_WIDTH_HALF: rd_ext = {16'd0, shifted[15:0]};
            default:        rd_ext = shifted;
        endcase
    end

    assign ready   = in_resp;
    assign data_rd = (in_resp && !req.we && !req.mis) ? rd_ext : 32'd0;
`ifdef MEM_MISALIGN_ERR_EN
    assign err     = in_resp && req.mis;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 3, 0) checked against a byte-array memory model.
module tb_mem_responder;

    localparam int NI = 3;
`ifdef MEM_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        valid   [NI];
    logic        we      [NI];
    logic [31:0] addr    [NI];
    logic [1:0]  width   [NI];
    logic [31:0] data_wr [NI];
    logic [31:0] data_rd [NI];
    logic        ready   [NI];
`ifdef MEM_MISALIGN_ERR_EN
    logic        err     [NI];
`endif

    int tests, fails;
    logic [7:0] mdl [NI][4096];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        mem_responder #(.ADDR_BITS(12), .WAIT_STATES(WS)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .valid   (valid[g]),
            .we      (we[g]),
            .addr    (addr[g]),
            .width   (width[g]),
            .data_wr (data_wr[g]),
            .data_rd (data_rd[g]),
            .ready   (ready[g])
`ifdef MEM_MISALIGN_ERR_EN
            ,
            .err     (err[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mload(input int k, input int a, input int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = mdl[k][a + i];
        return r;
    endfunction

    // One complete transaction; inputs are scrambled after acceptance to prove they were latched.
    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [1:0] wd,
                          input logic [31:0] d, input string nm, output logic [31:0] rd_o);
        int lat = 0, n, a12, ea;
        bit got = 0, idle_bad = 0, mis;
        logic [31:0] rd = 32'd0, exp_rd;
        logic e = 1'b0, exp_e;
        @(negedge clk);
        valid[k] = 1'b1; we[k] = w; addr[k] = a; width[k] = wd; data_wr[k] = d;
        while (!got && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (ready[k]) begin
                got = 1; rd = data_rd[k];
`ifdef MEM_MISALIGN_ERR_EN
                e = err[k];
`endif
            end else if (data_rd[k] !== 32'd0) idle_bad = 1;
            if (lat == 1) begin
                addr[k] = $urandom; data_wr[k] = $urandom; we[k] = 1'($urandom); width[k] = 2'($urandom);
            end
        end
        valid[k] = 1'b0;
        tests++;
        if (!got || lat != ws_of(k) + 1) begin
            fails++; $display("FAIL %s latency: got %0d (ready=%0b) exp %0d", nm, lat, got, ws_of(k) + 1);
        end
        if (got) begin
            @(posedge clk); #1;
            if (data_rd[k] !== 32'd0) idle_bad = 1;
            tests++;
            if (ready[k] !== 1'b0) begin
                fails++; $display("FAIL %s ready_pulse: got %0b exp 0", nm, ready[k]);
            end
        end
        tests++;
        if (idle_bad) begin
            fails++; $display("FAIL %s idle_data_rd: got nonzero exp 0", nm);
        end
        n   = nbytes(wd);
        a12 = int'(a & 32'hFFF);
        mis = (a12 % n) != 0;
        ea  = a12 - (a12 % n);
        if (ERR_EN && mis) begin
            exp_e = 1'b1; exp_rd = 32'd0;
        end else begin
            exp_e = 1'b0;
            if (w) begin
                for (int i = 0; i < n; i++) mdl[k][ea + i] = d[8*i +: 8];
                exp_rd = 32'd0;
            end else exp_rd = mload(k, ea, n);
        end
        tests++;
        if (rd !== exp_rd) begin
            fails++; $display("FAIL %s data_rd: got %h exp %h", nm, rd, exp_rd);
        end
`ifdef MEM_MISALIGN_ERR_EN
        tests++;
        if (e !== exp_e) begin
            fails++; $display("FAIL %s err: got %0b exp %0b", nm, e, exp_e);
        end
`endif
        rd_o = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (ready[k] !== 1'b0 || data_rd[k] !== 32'd0) begin
                fails++; $display("FAIL reset_%0d: ready %0b data_rd %h exp 0 0", k, ready[k], data_rd[k]);
            end
`ifdef MEM_MISALIGN_ERR_EN
            tests++;
            if (err[k] !== 1'b0) begin
                fails++; $display("FAIL reset_err_%0d: got %0b exp 0", k, err[k]);
            end
`endif
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (ready[k] !== 1'b0 || data_rd[k] !== 32'd0) begin
                fails++; $display("FAIL post_reset_%0d: ready %0b data_rd %h exp 0 0", k, ready[k], data_rd[k]);
            end
        end
    endtask

    task automatic init_mem();
        logic [31:0] rd;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 64; a += 4) do_req(k, 1'b1, 32'(a), 2'd2, $urandom, "init", rd);
            for (int a = 'h100; a < 'h110; a += 4) do_req(k, 1'b1, 32'(a), 2'd2, $urandom, "init", rd);
            for (int a = 'h200; a < 'h208; a += 4) do_req(k, 1'b1, 32'(a), 2'd2, $urandom, "init", rd);
        end
    endtask

    task automatic test_plan();
        logic [31:0] rd;
        do_req(0, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF, "st_word", rd);
        do_req(0, 1'b0, 32'h100, 2'd2, 32'h0, "ld_word", rd);
        tests++;
        if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL plan_word: got %h exp deadbeef", rd); end
        do_req(0, 1'b1, 32'h100, 2'd2, 32'h11223344, "st_word2", rd);
        do_req(0, 1'b1, 32'h101, 2'd0, 32'h000000AA, "st_byte", rd);
        do_req(0, 1'b0, 32'h100, 2'd2, 32'h0, "ld_word_b", rd);
        tests++;
        if (rd !== 32'h1122AA44) begin fails++; $display("FAIL plan_byte_word: got %h exp 1122aa44", rd); end
        do_req(0, 1'b0, 32'h101, 2'd0, 32'h0, "ld_byte", rd);
        tests++;
        if (rd !== 32'h000000AA) begin fails++; $display("FAIL plan_byte: got %h exp 000000aa", rd); end
        do_req(0, 1'b1, 32'h102, 2'd1, 32'h00005566, "st_half", rd);
        do_req(0, 1'b0, 32'h102, 2'd1, 32'h0, "ld_half", rd);
        tests++;
        if (rd !== 32'h00005566) begin fails++; $display("FAIL plan_half: got %h exp 00005566", rd); end
        do_req(0, 1'b0, 32'h100, 2'd2, 32'h0, "ld_word_h", rd);
        tests++;
        if (rd !== 32'h5566AA44) begin fails++; $display("FAIL plan_half_word: got %h exp 5566aa44", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        do_req(0, 1'b0, 32'h102, 2'd2, 32'h0, "mis_word", rd);
        tests++;
        if (rd !== (ERR_EN ? 32'h0 : 32'h5566AA44)) begin
            fails++; $display("FAIL misalign_word: got %h", rd);
        end
        do_req(0, 1'b1, 32'h103, 2'd1, 32'h0000BEEF, "mis_half_st", rd);
        do_req(0, 1'b0, 32'h100, 2'd2, 32'h0, "mis_half_chk", rd);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bit seen = 0;
        do_req(1, 1'b1, 32'h200, 2'd2, 32'h0BADF00D, "abort_prior", rd);
        @(negedge clk);
        valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h200; width[1] = 2'd2; data_wr[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        if (ready[1]) seen = 1;
        @(posedge clk); #1;
        if (ready[1]) seen = 1;
        valid[1] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready[1]) seen = 1;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL abort_ready: got 1 exp 0"); end
        do_req(1, 1'b0, 32'h200, 2'd2, 32'h0, "abort_ld", rd);
        tests++;
        if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL abort_data: got %h exp 0badf00d", rd); end
    endtask

    task automatic test_rst_resp();
        logic [31:0] rd;
        int cyc = 0;
        do_req(1, 1'b1, 32'h204, 2'd2, 32'h12345678, "rst_prior", rd);
        @(negedge clk);
        valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h204; width[1] = 2'd2; data_wr[1] = 32'hCAFEF00D;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!ready[1] && cyc < 20);
        tests++;
        if (!ready[1]) begin fails++; $display("FAIL rst_resp_reach: got no ready in %0d cycles", cyc); end
        rst = 1'b1;
        #1;
        tests++;
        if (ready[1] !== 1'b0) begin fails++; $display("FAIL rst_resp_ready: got %0b exp 0", ready[1]); end
        valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'h204, 2'd2, 32'h0, "rst_ld", rd);
        tests++;
        if (rd !== 32'h12345678) begin fails++; $display("FAIL rst_resp_data: got %h exp 12345678", rd); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, c1 = -1, c2 = -1;
        logic [31:0] rd1 = 32'd0, rd2 = 32'd0;
        @(negedge clk);
        valid[0] = 1'b1; we[0] = 1'b0; width[0] = 2'd2; addr[0] = 32'h1100; data_wr[0] = 32'h0;
        while (c2 < 0 && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (ready[0]) begin
                if (c1 < 0) begin c1 = cyc; rd1 = data_rd[0]; addr[0] = 32'h104; end
                else begin c2 = cyc; rd2 = data_rd[0]; end
            end
        end
        valid[0] = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (c1 < 0 || c2 < 0 || c2 - c1 != ws_of(0) + 2) begin
            fails++; $display("FAIL b2b_spacing: got c1=%0d c2=%0d exp gap %0d", c1, c2, ws_of(0) + 2);
        end
        tests++;
        if (rd1 !== mload(0, 'h100, 4)) begin
            fails++; $display("FAIL b2b_alias: got %h exp %h", rd1, mload(0, 'h100, 4));
        end
        tests++;
        if (rd2 !== mload(0, 'h104, 4)) begin
            fails++; $display("FAIL b2b_second: got %h exp %h", rd2, mload(0, 'h104, 4));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 40; i++) begin
                a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << 12);
                do_req(k, 1'($urandom), a, 2'($urandom_range(0, 3)), $urandom, "rand", rd);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            valid[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; width[k] = 2'd0; data_wr[k] = 32'd0;
        end
        test_reset();
        init_mem();
        test_plan();
        test_misalign();
        test_abort();
        test_rst_resp();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
